// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared ASCII codes and FSM state type for the text terminal writer
package term_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        IDLE       = 2'd1,
        CLEAR_LINE = 2'd2
    } term_state_t;

endpackage

// File: rtl/text_terminal_writer.sv
// rtl/text_terminal_writer.sv - ASCII byte stream to character-buffer cell writes and cursor
module text_terminal_writer
    import term_pkg::*;
#(
    parameter int         CHAR_HORZ_CNT = 80,
    parameter int         CHAR_VERT_CNT = 30,
    parameter int         CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
    parameter int         CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
    parameter logic [7:0] CLEAR_CHAR    = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   char_write_en,
    output logic [CHAR_HORZ_W-1:0] char_hpos,
    output logic [CHAR_VERT_W-1:0] char_vpos,
    output logic [7:0]             char_symbol,
    output logic                   cursor_en,
    output logic [CHAR_HORZ_W-1:0] cursor_hpos,
    output logic [CHAR_VERT_W-1:0] cursor_vpos
);

    localparam logic [CHAR_HORZ_W-1:0] COL_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
    localparam logic [CHAR_VERT_W-1:0] ROW_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);

    term_state_t            r_state;
    term_state_t            w_state_nxt;

    logic [CHAR_HORZ_W-1:0] r_cur_col,  w_cur_col;
    logic [CHAR_VERT_W-1:0] r_cur_row,  w_cur_row;
    logic [CHAR_HORZ_W-1:0] r_clr_col,  w_clr_col;
    logic [CHAR_VERT_W-1:0] r_clr_row,  w_clr_row;
    // Set once the final clear strobe has been issued; the following cycle
    // returns to IDLE so in_ready rises the cycle after the last strobe.
    logic                   r_clr_done, w_clr_done;

    logic                   r_in_ready;
    logic                   r_char_we,  w_char_we;
    logic [CHAR_HORZ_W-1:0] r_char_hpos, w_char_hpos;
    logic [CHAR_VERT_W-1:0] r_char_vpos, w_char_vpos;
    logic [7:0]             r_char_symbol, w_char_symbol;
    logic                   w_row_adv;
    logic                   w_printable;

    assign w_printable = (in_data >= ASCII_SPACE) && (in_data <= ASCII_TILDE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ALL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next cursor/clear counters and next write strobe
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_col     = r_cur_col;
        w_cur_row     = r_cur_row;
        w_clr_col     = r_clr_col;
        w_clr_row     = r_clr_row;
        w_clr_done    = r_clr_done;
        w_char_we     = 1'b0;
        w_char_hpos   = r_char_hpos;
        w_char_vpos   = r_char_vpos;
        w_char_symbol = r_char_symbol;
        w_row_adv     = 1'b0;

        case (r_state)
            CLEAR_ALL: begin
                if (r_clr_done) begin
                    w_clr_done  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_char_we     = 1'b1;
                    w_char_hpos   = r_clr_col;
                    w_char_vpos   = r_clr_row;
                    w_char_symbol = CLEAR_CHAR;
                    if (r_clr_col == COL_LAST) begin
                        w_clr_col = '0;
                        if (r_clr_row == ROW_LAST) begin
                            w_clr_row  = '0;
                            w_clr_done = 1'b1;
                        end else begin
                            w_clr_row = r_clr_row + 1'b1;
                        end
                    end else begin
                        w_clr_col = r_clr_col + 1'b1;
                    end
                end
            end

            IDLE: begin
                if (in_valid) begin
                    if (w_printable) begin
                        w_char_we     = 1'b1;
                        w_char_hpos   = r_cur_col;
                        w_char_vpos   = r_cur_row;
                        w_char_symbol = in_data;
                        if (r_cur_col == COL_LAST) begin
                            w_cur_col = '0;
                            w_row_adv = 1'b1;
                        end else begin
                            w_cur_col = r_cur_col + 1'b1;
                        end
                    end else if (in_data == ASCII_CR) begin
                        w_cur_col = '0;
                    end else if (in_data == ASCII_LF) begin
                        w_row_adv = 1'b1;
                    end else if (in_data == ASCII_BS) begin
                        // Backspace never climbs to the previous row.
                        if (r_cur_col != '0) begin
                            w_cur_col     = r_cur_col - 1'b1;
                            w_char_we     = 1'b1;
                            w_char_hpos   = r_cur_col - 1'b1;
                            w_char_vpos   = r_cur_row;
                            w_char_symbol = CLEAR_CHAR;
                        end
                    end
                end

                if (w_row_adv) begin
                    if (r_cur_row == ROW_LAST) begin
                        // Screen wrap: the new top row holds stale text, blank it.
                        w_cur_row   = '0;
                        w_clr_col   = '0;
                        w_clr_done  = 1'b0;
                        w_state_nxt = CLEAR_LINE;
                    end else begin
                        w_cur_row = r_cur_row + 1'b1;
                    end
                end
            end

            CLEAR_LINE: begin
                if (r_clr_done) begin
                    w_clr_done  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_char_we     = 1'b1;
                    w_char_hpos   = r_clr_col;
                    w_char_vpos   = r_cur_row;
                    w_char_symbol = CLEAR_CHAR;
                    if (r_clr_col == COL_LAST) begin
                        w_clr_col  = '0;
                        w_clr_done = 1'b1;
                    end else begin
                        w_clr_col = r_clr_col + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = CLEAR_ALL;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_col     <= '0;
            r_cur_row     <= '0;
            r_clr_col     <= '0;
            r_clr_row     <= '0;
            r_clr_done    <= 1'b0;
            r_in_ready    <= 1'b0;
            r_char_we     <= 1'b0;
            r_char_hpos   <= '0;
            r_char_vpos   <= '0;
            r_char_symbol <= '0;
        end else begin
            r_cur_col     <= w_cur_col;
            r_cur_row     <= w_cur_row;
            r_clr_col     <= w_clr_col;
            r_clr_row     <= w_clr_row;
            r_clr_done    <= w_clr_done;
            r_in_ready    <= (w_state_nxt == IDLE);
            r_char_we     <= w_char_we;
            r_char_hpos   <= w_char_hpos;
            r_char_vpos   <= w_char_vpos;
            r_char_symbol <= w_char_symbol;
        end
    end

    assign in_ready      = r_in_ready;
    assign cursor_en     = r_in_ready;
    assign char_write_en = r_char_we;
    assign char_hpos     = r_char_hpos;
    assign char_vpos     = r_char_vpos;
    assign char_symbol   = r_char_symbol;
    assign cursor_hpos   = r_cur_col;
    assign cursor_vpos   = r_cur_row;

endmodule
